// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial 1010 pattern generator.
package seq_gen_pkg;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Default pattern width and the pattern the detectors look for.
  localparam int unsigned DEF_PAT_W = 4;
  localparam logic [3:0]  PAT_1010  = 4'b1010;

endpackage

// File: rtl/seq_generator_1010.sv
// Serial pattern transmitter: sends PATTERN MSB-first for a requested number of
// repetitions, with an optional idle gap between repetitions. All outputs registered.
module seq_generator_1010
  import seq_gen_pkg::*;
#(
  parameter int unsigned          PAT_W      = DEF_PAT_W,
  parameter logic [PAT_W-1:0]     PATTERN    = PAT_W'(PAT_1010),
  parameter int unsigned          GAP_CYCLES = 0,
  parameter int unsigned          REP_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             out,
  output logic             valid,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BitW = $clog2(PAT_W);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Index of the final bit, and of the bit just before it (drives the last marker).
  localparam logic [BitW-1:0] BitLast = BitW'(PAT_W - 1);
  localparam logic [BitW-1:0] BitPen  = BitW'(PAT_W - 2);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e           state_q;
  logic [PAT_W-1:0] sh_q;       // bits still to be sent, next one at the MSB
  logic [BitW-1:0]  bit_cnt_q;  // index of the bit currently on out
  logic [REP_W-1:0] rep_cnt_q;  // repetitions remaining, including the current one
  logic [GapW-1:0]  gap_cnt_q;

  // Single FSM: state, datapath counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      out       <= 1'b0;
      valid     <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // abort has priority over start in IDLE.
          if (start && !abort) begin
            if (reps == '0) begin
              done <= 1'b1;
            end else begin
              state_q   <= ST_SEND;
              rep_cnt_q <= reps;
              sh_q      <= {PATTERN[PAT_W-2:0], 1'b0};
              bit_cnt_q <= '0;
              out       <= PATTERN[PAT_W-1];
              valid     <= 1'b1;
              last      <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end

        ST_SEND: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            rep_cnt_q <= '0;
            out       <= 1'b0;
            valid     <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
          end else if (bit_cnt_q != BitLast) begin
            out       <= sh_q[PAT_W-1];
            sh_q      <= {sh_q[PAT_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            last      <= (bit_cnt_q == BitPen);
          end else if (rep_cnt_q != REP_W'(1)) begin
            rep_cnt_q <= rep_cnt_q - 1'b1;
            if (GAP_CYCLES > 0) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= '0;
              out       <= 1'b0;
              valid     <= 1'b0;
              last      <= 1'b0;
            end else begin
              // Back-to-back: next MSB follows the last bit with no bubble.
              sh_q      <= {PATTERN[PAT_W-2:0], 1'b0};
              bit_cnt_q <= '0;
              out       <= PATTERN[PAT_W-1];
              valid     <= 1'b1;
              last      <= 1'b0;
            end
          end else begin
            state_q   <= ST_IDLE;
            rep_cnt_q <= '0;
            out       <= 1'b0;
            valid     <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end

        ST_GAP: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            busy      <= 1'b0;
          end else if (gap_cnt_q == GapLast) begin
            state_q   <= ST_SEND;
            sh_q      <= {PATTERN[PAT_W-2:0], 1'b0};
            bit_cnt_q <= '0;
            out       <= PATTERN[PAT_W-1];
            valid     <= 1'b1;
            last      <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          out     <= 1'b0;
          valid   <= 1'b0;
          last    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_generator_1010.sv
// Bench for seq_generator_1010: two instances (no gap / two-cycle gap) share stimulus;
// expected per-cycle output vectors are queued at drive time and popped every cycle.
module tb_seq_generator_1010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] reps = '0;
  logic       abort = 1'b0;

  logic out0, valid0, last0, busy0, done0;
  logic out2, valid2, last2, busy2, done2;

  seq_generator_1010 #(.GAP_CYCLES(0), .REP_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .reps(reps), .abort(abort),
    .out(out0), .valid(valid0), .last(last0), .busy(busy0), .done(done0)
  );

  seq_generator_1010 #(.GAP_CYCLES(2), .REP_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .reps(reps), .abort(abort),
    .out(out2), .valid(valid2), .last(last2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  // Vector layout: {out, valid, last, busy, done}
  logic [4:0] obs0, obs2;
  assign obs0 = {out0, valid0, last0, busy0, done0};
  assign obs2 = {out2, valid2, last2, busy2, done2};

  logic [4:0] q0[$];
  logic [4:0] q2[$];
  logic [4:0] e0, e2;
  string      phase = "reset";
  int         n_cmp = 0;
  int         n_err = 0;
  int         vcnt0 = 0, lcnt0 = 0, vcnt2 = 0, lcnt2 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Scoreboard: compare one expected vector per DUT per cycle, #1 after the edge.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      check_eq({phase, "/g0"}, 32'(obs0), 32'(e0));
      if (obs0[3]) vcnt0++;
      if (obs0[2]) lcnt0++;
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      check_eq({phase, "/g2"}, 32'(obs2), 32'(e2));
      if (obs2[3]) vcnt2++;
      if (obs2[2]) lcnt2++;
    end
  end

  // Expected stream for r repetitions with gap g; keep<0 means full stream with done.
  task automatic push_stream(input int sel, input int r, input int g, input int keep,
                             input bit idle_tail);
    logic [4:0] tmp[$];
    logic [3:0] pat;
    int         n;
    pat = 4'b1010;
    for (int k = 0; k < r; k++) begin
      for (int b = 0; b < 4; b++) tmp.push_back({pat[3-b], 1'b1, (b == 3), 1'b1, 1'b0});
      if (k < r - 1) for (int j = 0; j < g; j++) tmp.push_back(5'b00010);
    end
    if (keep < 0) tmp.push_back(5'b00001);
    if (idle_tail) tmp.push_back(5'b00000);
    n = (keep < 0) ? tmp.size() : keep;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) q0.push_back(tmp[i]);
      else q2.push_back(tmp[i]);
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) begin
      q0.push_back(5'b00000);
      q2.push_back(5'b00000);
    end
  endtask

  // Called at a negedge: queue expectations, pulse start for one cycle.
  task automatic go(input int r, input int keep, input bit idle_tail);
    push_stream(0, r, 0, keep, idle_tail);
    push_stream(2, r, 2, keep, idle_tail);
    start = 1'b1;
    reps  = 4'(r);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (q0.size() > 0 || q2.size() > 0); i++) @(negedge clk);
    check_eq({phase, "/drain0"}, 32'(q0.size()), 0);
    check_eq({phase, "/drain2"}, 32'(q2.size()), 0);
    q0.delete();
    q2.delete();
  endtask

  initial begin
    // Reset held with start high: everything stays at zero.
    start = 1'b1;
    reps  = 4'd1;
    repeat (2) @(negedge clk);
    check_eq("reset/g0", 32'(obs0), 0);
    check_eq("reset/g2", 32'(obs2), 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);

    phase = "single";
    go(1, -1, 1'b1);
    drain();

    // start pulse during busy must not disturb the frame.
    phase = "b2b_ignore";
    go(3, -1, 1'b1);
    @(negedge clk);
    start = 1'b1;
    reps  = 4'd1;
    @(negedge clk);
    start = 1'b0;
    drain();

    phase = "reps0";
    go(0, -1, 1'b1);
    drain();

    // start in the done cycle begins the next frame immediately.
    phase = "chain";
    go(1, -1, 1'b0);
    repeat (4) @(negedge clk);
    go(1, -1, 1'b1);
    drain();

    phase = "abort_start_idle";
    push_idle(2);
    start = 1'b1;
    abort = 1'b1;
    reps  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    drain();

    phase = "abort_mid";
    go(2, 2, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    push_idle(2);
    @(negedge clk);
    abort = 1'b0;
    drain();

    // Reset while dut2 sits in its first gap cycle: outputs clear without an edge.
    phase = "reset_gap";
    go(2, 5, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("reset_gap/async0", 32'(obs0), 0);
    check_eq("reset_gap/async2", 32'(obs2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(3);
    drain();

    phase = "max_reps";
    vcnt0 = 0; lcnt0 = 0; vcnt2 = 0; lcnt2 = 0;
    go(15, -1, 1'b1);
    drain();
    check_eq("max/valid0", 32'(vcnt0), 60);
    check_eq("max/last0", 32'(lcnt0), 15);
    check_eq("max/valid2", 32'(vcnt2), 60);
    check_eq("max/last2", 32'(lcnt2), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Backstop against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected $finish");
    $fatal(1);
  end

endmodule
